// File: rtl/lvds_fifo_ctrl_if.sv
// Handshake and RAM-side signal bundle for the LVDS RX FIFO controller.
// The master side is the producer/consumer plus the RAM read port; the slave side is the controller.
interface lvds_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  clear_i;
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  afull_o;
  logic                  aempty_o;
  logic [ADDR_WIDTH:0]   wr_level_o;
  logic                  ovf_o;
  logic                  udf_o;
  logic                  ram_wren;
  logic [ADDR_WIDTH-1:0] ram_wraddress;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_rdaddress;
  logic [DATA_WIDTH-1:0] ram_q;

  modport master (
    output clear_i, wr_en_i, wr_data_i, rd_en_i, ram_q,
    input  rd_data_o, rd_valid_o, full_o, empty_o, afull_o, aempty_o, wr_level_o,
           ovf_o, udf_o, ram_wren, ram_wraddress, ram_data, ram_rdaddress
  );

  modport slave (
    input  clear_i, wr_en_i, wr_data_i, rd_en_i, ram_q,
    output rd_data_o, rd_valid_o, full_o, empty_o, afull_o, aempty_o, wr_level_o,
           ovf_o, udf_o, ram_wren, ram_wraddress, ram_data, ram_rdaddress
  );
endinterface

// File: rtl/lvds_fifo_ctrl.sv
// Single-clock FIFO controller sequencing a pipelined dual-port RAM as a synchronous FIFO.
// Hides the RAM's write pipeline via a one-cycle commit register on the readable count.
module lvds_fifo_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2
) (
  input logic             clock,
  input logic             reset,
  lvds_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_AFULL  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] LVL_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

  typedef enum logic [1:0] {ST_FLUSH0, ST_FLUSH1, ST_RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   wr_level, rd_level;
  logic                  commit, rd_valid, ovf, udf;
  logic                  run, flush_entry, push_acc, pop_acc;
  logic                  full, empty, afull, aempty;
  logic [DATA_WIDTH-1:0] rd_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_FLUSH0;
    else       state <= state_nxt;
  end

  // FLUSH spans two cycles so any write still in the RAM pipeline lands before RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FLUSH0: state_nxt = ST_FLUSH1;
      ST_FLUSH1: state_nxt = bus.clear_i ? ST_FLUSH0 : ST_RUN;
      ST_RUN:    state_nxt = bus.clear_i ? ST_FLUSH0 : ST_RUN;
      default:   state_nxt = ST_FLUSH0;
    endcase
  end

  always_comb begin
    run         = (state == ST_RUN);
    flush_entry = run & bus.clear_i;
    full        = ~run | (wr_level == LVL_FULL);
    empty       = ~run | (rd_level == '0);
    afull       = (wr_level >= LVL_AFULL);
    aempty      = (rd_level <= LVL_AEMPTY);
    push_acc    = run & bus.wr_en_i & ~full;
    pop_acc     = run & bus.rd_en_i & ~empty;
  end

  // Levels use pre-op flags: a push while full is rejected even with a concurrent pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_level <= '0;
      rd_level <= '0;
      commit   <= 1'b0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else if (flush_entry) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_level <= '0;
      rd_level <= '0;
      commit   <= 1'b0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      wr_level <= wr_level + {{ADDR_WIDTH{1'b0}}, push_acc} - {{ADDR_WIDTH{1'b0}}, pop_acc};
      rd_level <= rd_level + {{ADDR_WIDTH{1'b0}}, commit}   - {{ADDR_WIDTH{1'b0}}, pop_acc};
      commit   <= push_acc;
      rd_valid <= pop_acc;
      ovf      <= ovf | (run & bus.wr_en_i & full);
      udf      <= udf | (run & bus.rd_en_i & empty);
    end
  end

  assign rd_data           = bus.ram_q;
  assign bus.rd_data_o     = rd_data;
  assign bus.rd_valid_o    = rd_valid;
  assign bus.full_o        = full;
  assign bus.empty_o       = empty;
  assign bus.afull_o       = afull;
  assign bus.aempty_o      = aempty;
  assign bus.wr_level_o    = wr_level;
  assign bus.ovf_o         = ovf;
  assign bus.udf_o         = udf;
  assign bus.ram_wren      = push_acc;
  assign bus.ram_wraddress = wr_ptr;
  assign bus.ram_data      = bus.wr_data_i;
  assign bus.ram_rdaddress = rd_ptr;
endmodule

// File: tb/tb_lvds_fifo_ctrl.sv
// Directed + randomized bench for lvds_fifo_ctrl against a queue-based FIFO model,
// with a behavioural pipelined RAM attached to the controller's RAM port.
module tb_lvds_fifo_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lvds_fifo_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  lvds_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // RAM: write lands two edges after it is sampled; read address is registered.
  logic [31:0] mem [16];
  logic        p1_we, p2_we;
  logic [3:0]  p1_a, p2_a, ra_q;
  logic [31:0] p1_d, p2_d;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      p1_we <= 1'b0;
      p2_we <= 1'b0;
      ra_q  <= 4'd0;
    end else begin
      if (p2_we) mem[p2_a] <= p2_d;
      p2_we <= p1_we;
      p2_a  <= p1_a;
      p2_d  <= p1_d;
      p1_we <= bus.ram_wren;
      p1_a  <= bus.ram_wraddress;
      p1_d  <= bus.ram_data;
      ra_q  <= bus.ram_rdaddress;
    end
  end
  assign bus.ram_q = mem[ra_q];

  typedef struct {
    logic [31:0] d;
    int          e;
  } ent_t;

  ent_t        mq[$];
  int          ecnt = 0;
  bit          m_run = 0;
  int          m_fl = 2;
  bit          m_ovf = 0, m_udf = 0, m_vld = 0;
  logic [31:0] m_dat = '0;
  int          total = 0, passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // A word pushed at edge e becomes readable in the cycle after edge e+1.
  function automatic int readable();
    int n = 0;
    foreach (mq[i]) if (mq[i].e <= ecnt - 1) n++;
    return n;
  endfunction

  // Called at a negedge: check current outputs, drive one cycle of inputs, advance the model.
  task automatic step(input bit wr, input logic [31:0] d, input bit rd, input bit clr);
    int rdbl;
    bit xf, xe, pa, pp;
    rdbl = readable();
    xf = !m_run || mq.size() == 16;
    xe = !m_run || rdbl == 0;
    chk("full",     64'(bus.full_o),     64'(xf));
    chk("empty",    64'(bus.empty_o),    64'(xe));
    chk("wr_level", 64'(bus.wr_level_o), 64'(mq.size()));
    chk("afull",    64'(bus.afull_o),    64'(mq.size() >= 12));
    chk("aempty",   64'(bus.aempty_o),   64'(rdbl <= 2));
    chk("ovf",      64'(bus.ovf_o),      64'(m_ovf));
    chk("udf",      64'(bus.udf_o),      64'(m_udf));
    chk("rd_valid", 64'(bus.rd_valid_o), 64'(m_vld));
    if (m_vld) chk("rd_data", 64'(bus.rd_data_o), 64'(m_dat));
    pa = m_run && wr && !xf;
    pp = m_run && rd && !xe;
    bus.wr_en_i   = wr;
    bus.wr_data_i = d;
    bus.rd_en_i   = rd;
    bus.clear_i   = clr;
    #1;
    chk("ram_wren", 64'(bus.ram_wren), 64'(pa));
    @(posedge clock);
    ecnt++;
    m_vld = pp;
    if (pp) m_dat = mq.pop_front().d;
    if (pa) mq.push_back('{d: d, e: ecnt});
    if (m_run && wr && xf) m_ovf = 1;
    if (m_run && rd && xe) m_udf = 1;
    if (m_run) begin
      if (clr) begin
        mq.delete();
        m_ovf = 0; m_udf = 0; m_vld = 0;
        m_run = 0; m_fl = 2;
      end
    end else begin
      m_fl--;
      if (m_fl == 0) begin
        if (clr) m_fl = 2;
        else     m_run = 1;
      end
    end
    @(negedge clock);
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.clear_i = 1'b0;
  endtask

  initial begin
    bit w, r, c;
    bus.clear_i   = 1'b0;
    bus.wr_en_i   = 1'b0;
    bus.rd_en_i   = 1'b0;
    bus.wr_data_i = '0;
    repeat (3) @(negedge clock);
    chk("rst_full",   64'(bus.full_o),     64'(1));
    chk("rst_empty",  64'(bus.empty_o),    64'(1));
    chk("rst_afull",  64'(bus.afull_o),    64'(0));
    chk("rst_aempty", 64'(bus.aempty_o),   64'(1));
    chk("rst_level",  64'(bus.wr_level_o), 64'(0));
    chk("rst_valid",  64'(bus.rd_valid_o), 64'(0));
    chk("rst_ovf",    64'(bus.ovf_o),      64'(0));
    chk("rst_udf",    64'(bus.udf_o),      64'(0));
    reset = 1'b0;

    // Two FLUSH cycles after reset, then RUN.
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    chk("run_full",  64'(bus.full_o),  64'(0));
    chk("run_empty", 64'(bus.empty_o), 64'(1));

    // Single word: push-to-pop latency and read latency.
    step(1, 32'hA5A5_0001, 0, 0);
    chk("lat_empty_k", 64'(bus.empty_o), 64'(1));
    step(0, '0, 0, 0);
    chk("lat_empty_k1", 64'(bus.empty_o), 64'(0));
    step(0, '0, 1, 0);
    chk("lat_valid", 64'(bus.rd_valid_o), 64'(1));
    chk("lat_data",  64'(bus.rd_data_o),  64'(32'hA5A5_0001));
    step(0, '0, 0, 0);

    // Fill to full, overflow, then push+pop while full.
    for (int i = 0; i < 16; i++) step(1, 32'(i), 0, 0);
    chk("fill_level", 64'(bus.wr_level_o), 64'(16));
    chk("fill_full",  64'(bus.full_o),     64'(1));
    chk("fill_afull", 64'(bus.afull_o),    64'(1));
    step(1, 32'hDEAD_0017, 0, 0);
    chk("ovf_set", 64'(bus.ovf_o), 64'(1));
    step(1, 32'hDEAD_0018, 1, 0);
    chk("pp_full_level", 64'(bus.wr_level_o), 64'(15));
    for (int i = 0; i < 17; i++) step(0, '0, 1, 0);

    // Flush clears sticky flags.
    step(0, '0, 0, 1);
    repeat (3) step(0, '0, 0, 0);
    chk("flush_ovf", 64'(bus.ovf_o), 64'(0));

    // Interleaved traffic across pointer wrap, kept legal.
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 3) != 0) && (mq.size() < 16);
      r = ($urandom_range(0, 1) != 0) && (readable() > 0);
      step(w, $urandom, r, 0);
    end
    while (mq.size() > 0) step(0, '0, readable() > 0, 0);
    step(0, '0, 0, 0);
    chk("wrap_ovf", 64'(bus.ovf_o), 64'(0));
    chk("wrap_udf", 64'(bus.udf_o), 64'(0));

    // Unconstrained random traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 24) == 0);
      step(w, $urandom, r, c);
    end

    // Underflow, then clear with 5 words stored.
    step(0, '0, 0, 1);
    repeat (2) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    chk("udf_set",   64'(bus.udf_o),      64'(1));
    chk("udf_valid", 64'(bus.rd_valid_o), 64'(0));
    for (int i = 0; i < 5; i++) step(1, 32'h5000 + 32'(i), 0, 0);
    step(0, '0, 0, 0);
    chk("pre_clr_level", 64'(bus.wr_level_o), 64'(5));
    step(0, '0, 1, 1);
    chk("flush_valid", 64'(bus.rd_valid_o), 64'(0));
    chk("flush_full",  64'(bus.full_o),     64'(1));
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    chk("post_empty", 64'(bus.empty_o),    64'(1));
    chk("post_full",  64'(bus.full_o),     64'(0));
    chk("post_level", 64'(bus.wr_level_o), 64'(0));
    chk("post_udf",   64'(bus.udf_o),      64'(0));
    step(0, '0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
